// File: rtl/bus_read_collector_if.sv
// Core-side load/store bus between the core, the read collector and the read sources.
interface bus_read_collector_if #(
  parameter int unsigned RDSEL_WIDTH = 3
);
  logic                   req_i;
  logic                   we_i;
  logic [RDSEL_WIDTH-1:0] RDsel_i;
  logic [31:0]            mem_rdata_i;
  logic [15:0]            leds_rdata_i;
  logic [31:0]            hex_rdata_i;
  logic [15:0]            sw_rdata_i;
  logic [7:0]             ps2_rdata_i;
  logic                   ps2_valid_i;
  logic                   ps2_ack_o;
  logic                   stall_o;
  logic                   rvalid_o;
  logic [31:0]            rdata_o;
  logic                   err_o;

  modport master (
    output req_i, we_i, RDsel_i, mem_rdata_i, leds_rdata_i, hex_rdata_i,
           sw_rdata_i, ps2_rdata_i, ps2_valid_i,
    input  ps2_ack_o, stall_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, we_i, RDsel_i, mem_rdata_i, leds_rdata_i, hex_rdata_i,
           sw_rdata_i, ps2_rdata_i, ps2_valid_i,
    output ps2_ack_o, stall_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/bus_read_collector.sv
// Read-response collector: waits for the selected source, returns one registered
// read word with an error flag, drives the core stall and times out PS/2 reads.
module bus_read_collector #(
  parameter int unsigned RDSEL_WIDTH = 3,
  parameter int unsigned TIMEOUT     = 1024
) (
  input logic                 clk_i,
  input logic                 rst_i,
  bus_read_collector_if.slave bus
);

  localparam logic [RDSEL_WIDTH-1:0] SEL_MEM  = RDSEL_WIDTH'(0);
  localparam logic [RDSEL_WIDTH-1:0] SEL_LEDS = RDSEL_WIDTH'(1);
  localparam logic [RDSEL_WIDTH-1:0] SEL_HEX  = RDSEL_WIDTH'(2);
  localparam logic [RDSEL_WIDTH-1:0] SEL_PS2  = RDSEL_WIDTH'(3);
  localparam logic [RDSEL_WIDTH-1:0] SEL_SW   = RDSEL_WIDTH'(4);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WAIT_PS2,
    RESP
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;
  logic               stall;
  logic               ps2_ack;

  // The accepted select code is carried by the state it leads to, so no separate
  // select register is kept.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    stall   = 1'b0;
    ps2_ack = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_i && !bus.we_i) begin
          stall = 1'b1;
          case (bus.RDsel_i)
            SEL_MEM: state_d = WAIT_MEM;
            SEL_PS2: begin
              state_d = WAIT_PS2;
              cnt_d   = '0;
            end
            SEL_LEDS: begin
              rdata_d = {16'b0, bus.leds_rdata_i};
              err_d   = 1'b0;
              state_d = RESP;
            end
            SEL_HEX: begin
              rdata_d = bus.hex_rdata_i;
              err_d   = 1'b0;
              state_d = RESP;
            end
            SEL_SW: begin
              rdata_d = {16'b0, bus.sw_rdata_i};
              err_d   = 1'b0;
              state_d = RESP;
            end
            default: begin
              rdata_d = '0;
              err_d   = 1'b1;
              state_d = RESP;
            end
          endcase
        end
      end

      WAIT_MEM: begin
        stall   = 1'b1;
        rdata_d = bus.mem_rdata_i;
        err_d   = 1'b0;
        state_d = RESP;
      end

      WAIT_PS2: begin
        stall = 1'b1;
        // Arriving data takes priority over an expiring timeout.
        if (bus.ps2_valid_i) begin
          ps2_ack = 1'b1;
          rdata_d = {24'b0, bus.ps2_rdata_i};
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.stall_o   = stall;
  assign bus.ps2_ack_o = ps2_ack;
  assign bus.rvalid_o  = (state_q == RESP);
  assign bus.rdata_o   = rdata_q;
  assign bus.err_o     = err_q;

endmodule

// File: tb/tb_bus_read_collector.sv
// Self-checking bench for bus_read_collector: table-driven reads, hand-written PS/2
// and reset sequences, and a scoreboard matching every rvalid_o to an expected word.
module tb_bus_read_collector;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  always #5 clk_i = ~clk_i;

  bus_read_collector_if #(.RDSEL_WIDTH(3)) bus ();

  bus_read_collector #(
    .RDSEL_WIDTH(3),
    .TIMEOUT    (4)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          at_cyc;
  } resp_t;

  resp_t exp_q[$];

  typedef struct {
    logic [2:0]  sel;
    logic [31:0] src;
    logic [31:0] exp_d;
    logic        exp_e;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Scoreboard: every rvalid_o must match the oldest expected response.
  always @(negedge clk_i) begin
    if (bus.rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", 32'd1, 32'd0);
      end else begin
        resp_t r;
        r = exp_q.pop_front();
        check("rdata", bus.rdata_o, r.data);
        check("err", {31'b0, bus.err_o}, {31'b0, r.err});
        check("rvalid_cycle", cyc, r.at_cyc);
      end
    end
  end

  task automatic drive_sources(input logic [31:0] src, input int c);
    bus.mem_rdata_i  = (c == 1) ? src : ~src;
    bus.leds_rdata_i = (c == 0) ? src[15:0] : ~src[15:0];
    bus.hex_rdata_i  = (c == 0) ? src : ~src;
    bus.sw_rdata_i   = (c == 0) ? src[15:0] : ~src[15:0];
  endtask

  // Starts in cycle 0 just after a rising edge; ends in the cycle after RESP.
  task automatic read_txn(input logic [2:0] sel, input logic [31:0] src,
                          input logic [7:0] code, input int ps2_at,
                          input logic [31:0] exp_d, input logic exp_e, input int lat);
    resp_t r;
    r.data   = exp_d;
    r.err    = exp_e;
    r.at_cyc = cyc + lat;
    exp_q.push_back(r);
    bus.req_i       = 1'b1;
    bus.we_i        = 1'b0;
    bus.RDsel_i     = sel;
    bus.ps2_rdata_i = code;
    for (int c = 0; c <= lat; c++) begin
      drive_sources(src, c);
      bus.ps2_valid_i = (ps2_at >= 0) && (c == ps2_at);
      @(negedge clk_i);
      check($sformatf("stall_c%0d", c), {31'b0, bus.stall_o}, {31'b0, (c < lat)});
      check($sformatf("ps2_ack_c%0d", c), {31'b0, bus.ps2_ack_o},
            {31'b0, (ps2_at >= 0) && (c == ps2_at)});
      @(posedge clk_i);
      #1;
    end
    bus.req_i       = 1'b0;
    bus.ps2_valid_i = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{sel: 3'd0, src: 32'h1234_5678, exp_d: 32'h1234_5678, exp_e: 1'b0, lat: 2};
    vecs[1] = '{sel: 3'd1, src: 32'h0000_A5A5, exp_d: 32'h0000_A5A5, exp_e: 1'b0, lat: 1};
    vecs[2] = '{sel: 3'd2, src: 32'hDEAD_BEEF, exp_d: 32'hDEAD_BEEF, exp_e: 1'b0, lat: 1};
    vecs[3] = '{sel: 3'd4, src: 32'h0000_FFFF, exp_d: 32'h0000_FFFF, exp_e: 1'b0, lat: 1};
    vecs[4] = '{sel: 3'd6, src: 32'hFFFF_FFFF, exp_d: 32'h0000_0000, exp_e: 1'b1, lat: 1};
    vecs[5] = '{sel: 3'd5, src: 32'h5555_AAAA, exp_d: 32'h0000_0000, exp_e: 1'b1, lat: 1};
    vecs[6] = '{sel: 3'd0, src: 32'h0BAD_F00D, exp_d: 32'h0BAD_F00D, exp_e: 1'b0, lat: 2};

    bus.req_i        = 1'b0;
    bus.we_i         = 1'b0;
    bus.RDsel_i      = 3'd0;
    bus.mem_rdata_i  = '0;
    bus.leds_rdata_i = '0;
    bus.hex_rdata_i  = '0;
    bus.sw_rdata_i   = '0;
    bus.ps2_rdata_i  = '0;
    bus.ps2_valid_i  = 1'b0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_stall", {31'b0, bus.stall_o}, 32'd0);
    check("rst_rvalid", {31'b0, bus.rvalid_o}, 32'd0);
    check("rst_rdata", bus.rdata_o, 32'd0);
    check("rst_err", {31'b0, bus.err_o}, 32'd0);
    check("rst_ack", {31'b0, bus.ps2_ack_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // Table-driven basic reads, issued back to back
    for (int i = 0; i < 7; i++)
      read_txn(vecs[i].sel, vecs[i].src, 8'h00, -1, vecs[i].exp_d, vecs[i].exp_e, vecs[i].lat);

    // Writes in IDLE: no stall, no response, read data held
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.RDsel_i = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("write_stall", {31'b0, bus.stall_o}, 32'd0);
      check("rdata_hold", bus.rdata_o, 32'h0BAD_F00D);
      @(posedge clk_i);
      #1;
    end
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;

    // Reset while waiting on memory: read dropped, outputs cleared
    bus.req_i       = 1'b1;
    bus.RDsel_i     = 3'd0;
    bus.mem_rdata_i = 32'hCAFE_0001;
    @(negedge clk_i);
    check("rstmid_stall_c0", {31'b0, bus.stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("rstmid_stall_c1", {31'b0, bus.stall_o}, 32'd1);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    bus.req_i = 1'b0;
    @(negedge clk_i);
    check("rstmid_stall", {31'b0, bus.stall_o}, 32'd0);
    check("rstmid_rvalid", {31'b0, bus.rvalid_o}, 32'd0);
    check("rstmid_rdata", bus.rdata_o, 32'd0);
    check("rstmid_err", {31'b0, bus.err_o}, 32'd0);
    check("rstmid_ack", {31'b0, bus.ps2_ack_o}, 32'd0);
    repeat (4) @(posedge clk_i);
    #1;

    // PS/2: data three cycles after acceptance
    read_txn(3'd3, 32'h0, 8'h1C, 3, 32'h0000_001C, 1'b0, 4);
    // PS/2: no data, timeout after TIMEOUT wait cycles
    read_txn(3'd3, 32'h0, 8'h77, -1, 32'h0000_0000, 1'b1, 5);
    // PS/2: data in the last wait cycle wins over the timeout
    read_txn(3'd3, 32'h0, 8'hE0, 4, 32'h0000_00E0, 1'b0, 5);
    // Immediately following memory read
    read_txn(3'd0, 32'h8765_4321, 8'h00, -1, 32'h8765_4321, 1'b0, 2);

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("missing_rvalid", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
